// File: rtl/spi_jtag_bridge.sv
// JTAG USER-register to SPI flash bridge: a header and a length field select the chip and
// the write length, then the bridge passes bits through (single) or unpacks nibbles (quad read).
module spi_jtag_bridge #(
  parameter int unsigned NUM_CS   = 2,
  parameter bit          QUAD_EN  = 1'b1,
  parameter int unsigned LEN_BITS = 16
) (
  input  logic              drck,
  input  logic              runtest,
  input  logic              sel,
  input  logic              capture,
  input  logic              shift,
  input  logic              update,
  input  logic              tdi,
  output logic              tdo,
  output logic [NUM_CS-1:0] csn,
  output logic              sck_en,
  output logic [3:0]        dq_o,
  output logic [3:0]        dq_oe,
  input  logic [3:0]        dq_i,
  output logic              busy
);

  typedef enum logic [2:0] {StIdle, StHdr, StLen, StWr, StRd1, StRdq, StErr} state_e;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [1:0]          cs_q, cs_d;
  logic                quad_q, quad_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [1:0]          ncnt_q, ncnt_d;
  logic [3:0]          nib_q, nib_d;
  logic                quad_rd;
  logic                active;
  logic [1:0]          nidx;

  assign quad_rd = quad_q && QUAD_EN;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    quad_d  = quad_q;
    len_d   = len_q;
    ncnt_d  = ncnt_q;
    nib_d   = nib_q;
    if (update && sel) begin
      state_d = StIdle;
      cnt_d   = '0;
      ncnt_d  = '0;
    end else if (capture && sel) begin
      state_d = StHdr;
      cnt_d   = '0;
      cs_d    = '0;
      quad_d  = 1'b0;
      len_d   = '0;
      ncnt_d  = '0;
      nib_d   = '0;
    end else if (shift && sel) begin
      unique case (state_q)
        StHdr: begin
          cnt_d = cnt_q + 5'd1;
          case (cnt_q)
            5'd0:    cs_d[0] = tdi;
            5'd1:    cs_d[1] = tdi;
            5'd2:    quad_d  = tdi;
            default: ;
          endcase
          if (cnt_q == 5'd7) begin
            cnt_d   = '0;
            state_d = ({1'b0, cs_d} >= 3'(NUM_CS)) ? StErr : StLen;
          end
        end
        StLen: begin
          len_d = {tdi, len_q[LEN_BITS-1:1]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(LEN_BITS - 1)) begin
            cnt_d = '0;
            if (len_d != '0)  state_d = StWr;
            else if (quad_rd) state_d = StRdq;
            else              state_d = StRd1;
          end
        end
        StWr: begin
          len_d = len_q - 1'b1;
          if (len_q == LEN_BITS'(1)) state_d = quad_rd ? StRdq : StRd1;
        end
        StRdq: begin
          ncnt_d = ncnt_q + 2'd1;
          if (ncnt_q == 2'd0) nib_d = dq_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge drck or posedge runtest) begin
    if (runtest) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cs_q    <= '0;
      quad_q  <= 1'b0;
      len_q   <= '0;
      ncnt_q  <= '0;
      nib_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      quad_q  <= quad_d;
      len_q   <= len_d;
      ncnt_q  <= ncnt_d;
      nib_q   <= nib_d;
    end
  end

  // Nibble bits leave LSB first; the bit shown at ncnt == 0 is the top of the previous nibble.
  assign nidx   = ncnt_q - 2'd1;
  assign active = (state_q == StWr) || (state_q == StRd1) || (state_q == StRdq);
  assign busy   = (state_q != StIdle);

  always_comb begin
    csn    = '1;
    sck_en = 1'b0;
    tdo    = tdi;
    dq_o   = 4'b1100;
    dq_oe  = 4'b1101;
    unique case (state_q)
      StWr, StRd1: begin
        sck_en = shift;
        dq_o   = {3'b110, tdi};
        tdo    = dq_i[1];
      end
      StRdq: begin
        dq_oe  = 4'b0000;
        sck_en = shift && (ncnt_q == 2'd0);
        tdo    = nib_q[nidx];
      end
      default: ;
    endcase
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (active && (cs_q == 2'(i))) csn[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_jtag_bridge.sv
// Directed bench for spi_jtag_bridge: stimulus queues expected output vectors, a monitor
// on the falling edge pops and compares them.
module tb_spi_jtag_bridge;

  logic       drck = 1'b0;
  logic       runtest, sel, capture, shift, update, tdi;
  logic       tdo, sck_en, busy;
  logic [1:0] csn;
  logic [3:0] dq_o, dq_oe, dq_i;

  spi_jtag_bridge #(.NUM_CS(2), .QUAD_EN(1'b1), .LEN_BITS(16)) dut (
    .drck    (drck),
    .runtest (runtest),
    .sel     (sel),
    .capture (capture),
    .shift   (shift),
    .update  (update),
    .tdi     (tdi),
    .tdo     (tdo),
    .csn     (csn),
    .sck_en  (sck_en),
    .dq_o    (dq_o),
    .dq_oe   (dq_oe),
    .dq_i    (dq_i),
    .busy    (busy)
  );

  always #5 drck = ~drck;

  typedef struct {
    string       nm;
    logic [12:0] e;
  } exp_t;

  exp_t exp_q[$];
  bit   chk = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Packed observation: {busy, sck_en, dq_oe, dq_o, csn, tdo}
  function automatic logic [12:0] ob(input logic b, input logic s, input logic [3:0] oe,
                                     input logic [3:0] o, input logic [1:0] cs, input logic t);
    return {b, s, oe, o, cs, t};
  endfunction

  function automatic logic [12:0] idle_o(input logic t);
    return ob(1'b0, 1'b0, 4'hD, 4'hC, 2'b11, t);
  endfunction

  always @(negedge drck) begin
    if (chk) begin
      logic [12:0] obs;
      exp_t        it;
      obs = {busy, sck_en, dq_oe, dq_o, csn, tdo};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: output %b with nothing expected", obs);
      end else begin
        it = exp_q.pop_front();
        if (obs !== it.e) begin
          n_fail++;
          $display("FAIL %s: got %b want %b (busy,sck_en,dq_oe,dq_o,csn,tdo)", it.nm, obs, it.e);
        end
      end
    end
  end

  task automatic cyc(input logic c, input logic s, input logic u, input logic t,
                     input logic [3:0] d, input bit ck, input string nm, input logic [12:0] e);
    capture = c;
    shift   = s;
    update  = u;
    tdi     = t;
    dq_i    = d;
    if (ck) exp_q.push_back('{nm, e});
    chk = ck;
    @(posedge drck);
    #1;
    chk = 1'b0;
  endtask

  task automatic shift_field(input logic [31:0] v, input int n, input string nm);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b1, 1'b0, v[i], 4'h0, 1'b1, nm, ob(1'b1, 1'b0, 4'hD, 4'hC, 2'b11, v[i]));
  endtask

  task automatic start(input logic [7:0] hdr, input logic [31:0] len);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "", '0);
    shift_field({24'h0, hdr}, 8, "hdr");
    shift_field(len, 16, "len");
  endtask

  initial begin
    logic [7:0]  cmd;
    logic [23:0] pat;
    logic [31:0] wdat;
    logic        t;
    logic        rq_exp[9];
    logic        q5_exp[5];
    rq_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    q5_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    runtest = 1'b1; sel = 1'b1; capture = 1'b0; shift = 1'b0; update = 1'b0;
    tdi = 1'b0; dq_i = 4'h0;
    @(posedge drck);
    #1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "reset", idle_o(1'b0));
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, "reset_echo", idle_o(1'b1));
    runtest = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, "idle", idle_o(1'b1));

    // Single write then read: 0x9F out MSB first, 0xEF4018 back on dq_i[1]
    start(8'h00, 32'd8);
    cmd = 8'h9F;
    for (int i = 7; i >= 0; i--) begin
      t = cmd[i];
      cyc(1'b0, 1'b1, 1'b0, t, {2'b00, ~t, 1'b0}, 1'b1, "wr_single",
          ob(1'b1, 1'b1, 4'hD, {3'b110, t}, 2'b10, ~t));
    end
    pat = 24'hEF4018;
    for (int i = 23; i >= 0; i--)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, {2'b00, pat[i], 1'b0}, 1'b1, "rd1_data",
          ob(1'b1, 1'b1, 4'hD, 4'hC, 2'b10, pat[i]));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, "rd1_upd_cyc", ob(1'b1, 1'b0, 4'hD, 4'hC, 2'b10, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, "idle_after_rd1", idle_o(1'b1));

    // Quad read on cs 1 after a 32-bit write with one hold cycle mid-write
    start(8'h05, 32'd32);
    wdat = 32'hC3A5_0F96;
    for (int i = 0; i < 32; i++) begin
      if (i == 16)
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, "wr_hold", ob(1'b1, 1'b0, 4'hD, 4'hD, 2'b01, 1'b0));
      t = wdat[i];
      cyc(1'b0, 1'b1, 1'b0, t, 4'h0, 1'b1, "wr_quad", ob(1'b1, 1'b1, 4'hD, {3'b110, t}, 2'b01, 1'b0));
    end
    for (int k = 0; k < 9; k++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, (k == 0) ? 4'hA : (k == 4) ? 4'h5 : 4'hF, 1'b1, "rdq_data",
          ob(1'b1, (k % 4) == 0, 4'h0, 4'hC, 2'b01, rq_exp[k]));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "", '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "idle_after_rdq", idle_o(1'b0));

    // Bad chip select: ERR ignores shift, echoes tdi, leaves on update
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "", '0);
    shift_field(32'h03, 8, "hdr_bad");
    for (int i = 0; i < 20; i++) begin
      t = (i % 3) == 1;
      cyc(1'b0, 1'b1, 1'b0, t, 4'hF, 1'b1, "err_hold", ob(1'b1, 1'b0, 4'hD, 4'hC, 2'b11, t));
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, "err_upd_cyc", ob(1'b1, 1'b0, 4'hD, 4'hC, 2'b11, 1'b1));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "idle_after_err", idle_o(1'b0));

    // Zero length with quad: RDQ immediately after LEN
    start(8'h04, 32'd0);
    for (int k = 0; k < 5; k++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, (k == 0) ? 4'h3 : 4'h0, 1'b1, "rdq_direct",
          ob(1'b1, (k % 4) == 0, 4'h0, 4'hC, 2'b10, q5_exp[k]));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "", '0);

    // Asynchronous reset mid-write, checked before the next rising edge
    start(8'h00, 32'd4);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, "wr_pre_rst", ob(1'b1, 1'b1, 4'hD, 4'hD, 2'b10, 1'b0));
    runtest = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, "async_rst", idle_o(1'b0));
    runtest = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "post_rst_idle", idle_o(1'b0));
    shift_field(32'h01, 8, "hdr_post_rst");
    shift_field(32'h0, 16, "len_post_rst");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 1'b1, "rd1_cs1", ob(1'b1, 1'b1, 4'hD, 4'hD, 2'b01, 1'b1));

    // Recapture during RD1, fresh header then write on cs 0
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "recap_cyc", ob(1'b1, 1'b0, 4'hD, 4'hC, 2'b01, 1'b0));
    shift_field(32'h00, 8, "hdr_recap");
    shift_field(32'h01, 16, "len_recap");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, "wr_recap", ob(1'b1, 1'b1, 4'hD, 4'hD, 2'b10, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 1'b1, "rd1_recap", ob(1'b1, 1'b1, 4'hD, 4'hC, 2'b10, 1'b1));

    // Capture and update together: update wins
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "", '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "cap_upd_idle", idle_o(1'b0));

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "", '0);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries remain, 0 required", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_jtag_bridge.md
SPI_JTAG_BRIDGE -- requirements
Module: spi_jtag_bridge

Interface
REQ-001 Parameter NUM_CS, default 2, range 1..4: number of chip selects.
REQ-002 Parameter QUAD_EN, default 1: 1 enables the quad-read phase; 0 forces single-bit read.
REQ-003 Parameter LEN_BITS, default 16, range 8..24: width of the write-length field.
REQ-004 Port drck, input, 1: sole clock (gated JTAG TCK); all state changes on its rising edge.
REQ-005 Port runtest, input, 1: reset, asynchronous, active-high.
REQ-006 Port sel, input, 1: USER instruction selected.
REQ-007 Ports capture, shift, update, input, 1 each: TAP Capture-DR, Shift-DR and Update-DR indications.
REQ-008 Port tdi, input, 1: JTAG serial data in.
REQ-009 Port tdo, output, 1: JTAG serial data out.
REQ-010 Port csn, output, NUM_CS: active-low flash chip selects.
REQ-011 Port sck_en, output, 1: the wrapper drives sck = drck only while sck_en is 1.
REQ-012 Ports dq_o, dq_oe, output, 4 each: flash DQ[3:0] output value and output enable.
REQ-013 Port dq_i, input, 4: flash DQ[3:0] input sample.
REQ-014 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, HDR, LEN, WR, RD1, RDQ, ERR.
REQ-016 In IDLE, capture && sel moves to HDR and clears the bit counter.
REQ-017 In HDR, while shift && sel, the block shifts 8 header bits, LSB first.
 - Bits [1:0] = cs_idx.
 - Bit [2] = quad_rd.
 - Bits [7:3] are ignored.
REQ-018 After 8 HDR bits: if cs_idx >= NUM_CS, go to ERR; otherwise go to LEN.
REQ-019 In LEN, the block shifts LEN_BITS bits (LSB first) into wr_len, then:
 - if wr_len != 0, go to WR;
 - if wr_len == 0 and quad_rd && QUAD_EN, go to RDQ;
 - otherwise go to RD1.
REQ-020 In IDLE, HDR, LEN and ERR:
 - all csn = 1, sck_en = 0, tdo = tdi;
 - dq_o = 4'b1100, dq_oe = 4'b1101.
REQ-021 In WR:
 - csn[cs_idx] = 0, sck_en = shift;
 - dq_o = {1, 1, 0, tdi}, dq_oe = 4'b1101;
 - tdo = dq_i[1].
REQ-022 The WR counter decrements on every shift cycle. When it reaches 0, the next state is RDQ if quad_rd && QUAD_EN, else RD1.
REQ-023 RD1 drives the same outputs as WR. RD1 has no length limit and persists until update.
REQ-024 In RDQ: csn[cs_idx] = 0, dq_oe = 4'b0000.
 - A 2-bit counter ncnt (starts at 0) advances on every shift cycle.
 - sck_en = shift && (ncnt == 0).
 - On the edge where ncnt == 0, nib <= dq_i.
 - tdo = nib[(ncnt-1) mod 4].
 - The first RDQ bit is pad (nib resets to 0); the host discards it.
REQ-025 Counters advance only when shift && sel is high. All states hold while shift is low.
REQ-026 update && sel in any state returns to IDLE with all csn = 1 at that edge.
REQ-027 capture && sel in any non-IDLE state restarts HDR: all csn = 1 and counters clear.
REQ-028 If capture and update are high on the same edge, update wins.
REQ-029 ERR ignores shift and exits only on update, capture or reset.

Reset
REQ-030 While runtest = 1:
 - state = IDLE, all csn = 1, sck_en = 0;
 - dq_o = 4'b1100, dq_oe = 4'b1101;
 - nib = 0, counters = 0, busy = 0.
REQ-031 Assertion of runtest mid-transfer deasserts csn immediately, without waiting for a clock edge.

Verification
REQ-032 Single write/read: header 0x00, wr_len 8, cmd 0x9F, then 24 read bits with dq_i[1] pattern 0xEF4018 -> csn[0] low exactly from the first WR bit; tdo returns 0xEF4018 after the header and length bits.
REQ-033 Quad read: header 0x05 (cs 1, quad), wr_len 32, then nibbles 0xA, 0x5 on dq_i -> csn[1] low; dq_oe = 0 after 32 bits; sck_en pulses every 4th shift; tdo = pad bit, then 0,1,0,1,1,0,1,0.
REQ-034 Bad chip select (NUM_CS = 2): header 0x03 -> state ERR; all csn stay high; tdo echoes tdi; update -> IDLE.
REQ-035 wr_len = 0 with quad: -> RDQ entered directly after the LEN field; no WR cycles occur.
REQ-036 Async reset: runtest pulsed during WR -> csn all 1 combinationally; busy = 0; next capture starts in HDR.
REQ-037 Recapture: capture during RD1 -> csn high on that edge; a fresh header is accepted.
